// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N packet producers.
// A grant is held for a whole packet; an idle granted producer is dropped after TIMEOUT cycles.
module fifo_wr_arbiter #(
  parameter int B       = 8,
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*B-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           timeout_q, timeout_d;

  logic           g_valid, g_last;
  logic [B-1:0]   g_data;
  logic           xfer;
  logic [IDW-1:0] next_ptr;
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   cand;

  // Beat of the currently granted requester.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == IDW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*B +: B];
      end
    end
  end

  assign xfer     = (state_q == BURST) && g_valid && !fifo_full;
  assign next_ptr = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;

  // First valid requester at or after rr_ptr; the wrap is explicit so N need not be a power of 2.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (!pick_found && cand == (IDW+1)'(i) && req_valid[i]) begin
          pick_found = 1'b1;
          pick_id    = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_id;
          idle_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (g_last) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end else if (!g_valid) begin
          if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            rr_ptr_d  = next_ptr;
            state_d   = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        // Valid but fifo full: counter holds, back-pressure never times out.
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == BURST);
    fifo_wr     = xfer;
    fifo_w_data = xfer ? g_data : '0;
    req_ready   = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = (state_q == BURST) && (grant_q == IDW'(i)) && !fifo_full;
    end
  end

  assign grant_id    = grant_q;
  assign timeout_err = timeout_q;

endmodule
